traffic_light_monitor: RTL

- Passive checker that observes the three light vectors driven by the intersection controller and decodes them into a phase.
- Measures how long each phase is held, in clock cycles, and checks both the phase sequence and each phase's duration against the timing parameters.
- Latches the first violation with a fault code and counts pedestrian crossings.
- Sits beside the controller on the same clock; drives a fault LED and debug displays, and serves as the in-bench scoreboard.

---
 rtl/tl_pkg.sv | 42 ++++
 rtl/tl_phase_decode.sv | 26 ++
 rtl/traffic_light_monitor.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared types for the traffic-light monitor: phase encoding, fault codes and
// the legal phase-sequence predicate.
// Pure declarations; no clocked logic lives here.
package tl_pkg;

    // Decoded intersection phase; value 6 is unused, 7 marks an undecodable pattern.
    typedef enum logic [2:0] {
        PH_ALLRED  = 3'd0,
        PH_MG      = 3'd1,
        PH_MY      = 3'd2,
        PH_SG      = 3'd3,
        PH_SY      = 3'd4,
        PH_PG      = 3'd5,
        PH_ILLEGAL = 3'd7
    } phase_e;

    // Fault codes; lower non-zero value wins when several fire together.
    typedef enum logic [2:0] {
        FC_NONE               = 3'd0,
        FC_ILLEGAL_PATTERN    = 3'd1,
        FC_ILLEGAL_TRANSITION = 3'd2,
        FC_DWELL_SHORT        = 3'd3,
        FC_DWELL_LONG         = 3'd4
    } fault_e;

    // True when the controller may move from from_ph directly to to_ph.
    function automatic logic legal_transition(input phase_e from_ph, input phase_e to_ph);
        logic ok;
        ok = 1'b0;
        case (from_ph)
            PH_ALLRED: ok = (to_ph == PH_MG);
            PH_MG:     ok = (to_ph == PH_MY);
            PH_MY:     ok = (to_ph == PH_SG);
            PH_SG:     ok = (to_ph == PH_SY);
            PH_SY:     ok = (to_ph == PH_MG) || (to_ph == PH_PG);
            PH_PG:     ok = (to_ph == PH_ALLRED);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/tl_phase_decode.sv
// Combinational decode of the three light vectors into a phase.
// Ports: main_lights/sec_lights {red,yellow,green}, pea_lights {red,green} in;
//        phase out (PH_ILLEGAL for any pattern not in the table).
module tl_phase_decode
    import tl_pkg::*;
(
    input  logic [2:0] main_lights,
    input  logic [2:0] sec_lights,
    input  logic [1:0] pea_lights,
    output phase_e     phase
);

    always_comb begin
        phase = PH_ILLEGAL;
        case ({main_lights, sec_lights, pea_lights})
            8'b100_100_10: phase = PH_ALLRED;
            8'b001_100_10: phase = PH_MG;
            8'b010_100_10: phase = PH_MY;
            8'b100_001_10: phase = PH_SG;
            8'b100_010_10: phase = PH_SY;
            8'b100_100_01: phase = PH_PG;
            default:       phase = PH_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive monitor: registers the decoded phase, times each phase, checks the
// sequence and dwell against the timing parameters, latches the first fault.
// Ports: clk/reset (async, active-high), light vectors and clr_fault in;
//        phase, phase_change, fault, fault_code, ped_count out.
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int FPGAFREQ      = 50_000_000,
    parameter int T_GREENMAIN   = 18,
    parameter int T_YELLOWMAIN  = 4,
    parameter int T_GREENSEC    = 10,
    parameter int T_YELLOWSEC   = 3,
    parameter int T_GREENPEATON = 5,
    parameter int T_REDPEATON   = 2,
    parameter int TOL_CYC       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] main_lights,
    input  logic [2:0] sec_lights,
    input  logic [1:0] pea_lights,
    input  logic       clr_fault,
    output logic [2:0] phase,
    output logic       phase_change,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] ped_count
);

    // Expected dwell per phase, in cycles; 64-bit to hold T*FPGAFREQ safely.
    localparam logic [63:0] FREQ     = 64'(FPGAFREQ);
    localparam logic [63:0] TOL      = 64'(TOL_CYC);
    localparam logic [63:0] E_MG     = 64'(T_GREENMAIN)   * FREQ;
    localparam logic [63:0] E_MY     = 64'(T_YELLOWMAIN)  * FREQ;
    localparam logic [63:0] E_SG     = 64'(T_GREENSEC)    * FREQ;
    localparam logic [63:0] E_SY     = 64'(T_YELLOWSEC)   * FREQ;
    localparam logic [63:0] E_PG     = 64'(T_GREENPEATON) * FREQ;
    localparam logic [63:0] E_ALLRED = 64'(T_REDPEATON)   * FREQ;

    localparam int MAXT_A = (T_GREENMAIN > T_YELLOWMAIN) ? T_GREENMAIN : T_YELLOWMAIN;
    localparam int MAXT_B = (T_GREENSEC > T_YELLOWSEC) ? T_GREENSEC : T_YELLOWSEC;
    localparam int MAXT_C = (T_GREENPEATON > T_REDPEATON) ? T_GREENPEATON : T_REDPEATON;
    localparam int MAXT_AB = (MAXT_A > MAXT_B) ? MAXT_A : MAXT_B;
    localparam int MAXT   = (MAXT_AB > MAXT_C) ? MAXT_AB : MAXT_C;

    // Wide enough to reach E+TOL_CYC+1 for the longest phase.
    localparam int DW = $clog2(64'(MAXT) * FREQ + TOL + 64'd2);

    function automatic logic [63:0] expected_dwell(input phase_e ph);
        logic [63:0] e;
        e = 64'd0;
        case (ph)
            PH_ALLRED: e = E_ALLRED;
            PH_MG:     e = E_MG;
            PH_MY:     e = E_MY;
            PH_SG:     e = E_SG;
            PH_SY:     e = E_SY;
            PH_PG:     e = E_PG;
            default:   e = 64'd0;
        endcase
        return e;
    endfunction

    phase_e          dec_phase;
    phase_e          phase_r;
    logic [DW-1:0]   dwell;
    logic            first_seg;
    // Clear until the first edge after reset; the reset-value phase was never
    // observed on the lights, so the move out of it is not a real controller transition.
    logic            primed;
    logic            fault_r;
    fault_e          code_r;
    logic [7:0]      ped_r;

    logic            chg;
    logic            checkable;
    logic [63:0]     dwell_w;
    logic [63:0]     e_cur;
    logic            f_pat;
    logic            f_trn;
    logic            f_short;
    logic            f_long;
    fault_e          new_code;

    tl_phase_decode u_decode (
        .main_lights (main_lights),
        .sec_lights  (sec_lights),
        .pea_lights  (pea_lights),
        .phase       (dec_phase)
    );

    always_comb begin
        chg       = (dec_phase != phase_r);
        dwell_w   = 64'(dwell);
        e_cur     = expected_dwell(phase_r);
        checkable = primed && !first_seg && (phase_r != PH_ILLEGAL);

        f_pat   = (dec_phase == PH_ILLEGAL);
        // Leaving ILLEGAL is never a checked transition.
        f_trn   = chg && primed && (phase_r != PH_ILLEGAL) && (dec_phase != PH_ILLEGAL)
                  && !legal_transition(phase_r, dec_phase);
        f_short = chg && checkable && ((dwell_w + TOL) < e_cur);
        // Fires on the edge that would take dwell to E+TOL+1.
        f_long  = !chg && checkable && (dwell_w == (e_cur + TOL));

        new_code = FC_NONE;
        if (f_pat)        new_code = FC_ILLEGAL_PATTERN;
        else if (f_trn)   new_code = FC_ILLEGAL_TRANSITION;
        else if (f_short) new_code = FC_DWELL_SHORT;
        else if (f_long)  new_code = FC_DWELL_LONG;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r      <= PH_ALLRED;
            phase_change <= 1'b0;
            dwell        <= '0;
            first_seg    <= 1'b1;
            primed       <= 1'b0;
            fault_r      <= 1'b0;
            code_r       <= FC_NONE;
            ped_r        <= 8'd0;
        end else begin
            primed       <= 1'b1;
            phase_r      <= dec_phase;
            phase_change <= chg;

            if (chg || !primed) begin
                dwell <= DW'(1);
            end else if (dwell != '1) begin
                dwell <= dwell + DW'(1);
            end

            // A segment starting right after reset or after ILLEGAL is exempt
            // from dwell checks.
            if (chg) begin
                first_seg <= !primed || (phase_r == PH_ILLEGAL);
            end

            if (new_code != FC_NONE && (!fault_r || clr_fault)) begin
                fault_r <= 1'b1;
                code_r  <= new_code;
            end else if (clr_fault) begin
                fault_r <= 1'b0;
                code_r  <= FC_NONE;
            end

            if (chg && dec_phase == PH_PG && ped_r != 8'hFF) begin
                ped_r <= ped_r + 8'd1;
            end
        end
    end

    assign phase      = phase_r;
    assign fault      = fault_r;
    assign fault_code = code_r;
    assign ped_count  = ped_r;

endmodule
